// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
// Bundles the fetch stage's control, memory and IF/ID signals.
//   start, stall, branch_taken, branch_target : sequencing from the core
//   imem_data / imem_addr                      : instruction memory read port
//   instr, instr_pc, instr_valid               : IF/ID register toward decode
//   done, fetch_count                          : status
// modport slave  : the fetch unit itself
// modport master : the surrounding core / memory / environment
// ---------------------------------------------------------------------------
interface fetch_unit_if #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
);
    logic              start;
    logic              stall;
    logic              branch_taken;
    logic [PC_W-1:0]   branch_target;
    logic [8:0]        imem_data;
    logic [PC_W-1:0]   imem_addr;
    logic [8:0]        instr;
    logic [PC_W-1:0]   instr_pc;
    logic              instr_valid;
    logic              done;
    logic [CNT_W-1:0]  fetch_count;

    modport master (
        output start, stall, branch_taken, branch_target, imem_data,
        input  imem_addr, instr, instr_pc, instr_valid, done, fetch_count
    );

    modport slave (
        input  start, stall, branch_taken, branch_target, imem_data,
        output imem_addr, instr, instr_pc, instr_valid, done, fetch_count
    );
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage of the R.O.E 9-bit core. Owns the program counter,
// addresses instruction memory (combinational read), and registers fetched
// words into the IF/ID register that feeds the control decoder.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset
//   bus    : fetch_unit_if.slave (see interface header for signal roles)
// Sequencing: IDLE --start--> RUN --halt word--> HALTED --start--> RUN.
// In RUN the priority is branch > stall > halt word > normal fetch.
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int         PC_W       = 10,
    parameter logic [8:0] HALT_INSTR = 9'h1FF,
    parameter int         CNT_W      = 16
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    localparam logic [PC_W-1:0]  PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [8:0]       instr_q, instr_d;
    logic [PC_W-1:0]  instr_pc_q, instr_pc_d;
    logic             instr_valid_q, instr_valid_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] fetch_count_q, fetch_count_d;

    // State register and IF/ID register with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            instr_q       <= 9'h000;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            done_q        <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            done_q        <= done_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Next-state and next-register logic for the fetch sequencer.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        done_d        = done_q;
        fetch_count_d = fetch_count_q;

        case (state_q)
            S_IDLE: begin
                instr_valid_d = 1'b0;
                if (bus.start) begin
                    state_d       = S_RUN;
                    pc_d          = '0;
                    fetch_count_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_RUN: begin
                if (bus.branch_taken) begin
                    // Redirect flushes the word fetched this cycle; it is
                    // neither counted nor checked for halt.
                    pc_d          = bus.branch_target;
                    instr_valid_d = 1'b0;
                end else if (bus.stall) begin
                    state_d = S_RUN;
                end else if (bus.imem_data == HALT_INSTR) begin
                    // The halt word never reaches decode.
                    state_d       = S_HALTED;
                    instr_valid_d = 1'b0;
                    done_d        = 1'b1;
                end else begin
                    instr_d       = bus.imem_data;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    pc_d          = pc_q + PC_ONE;
                    if (fetch_count_q != CNT_MAX) begin
                        fetch_count_d = fetch_count_q + CNT_ONE;
                    end else begin
                        fetch_count_d = fetch_count_q;
                    end
                end
            end

            S_HALTED: begin
                instr_valid_d = 1'b0;
                if (bus.start) begin
                    state_d       = S_RUN;
                    pc_d          = '0;
                    fetch_count_d = '0;
                    done_d        = 1'b0;
                end else begin
                    done_d = 1'b1;
                end
            end

            default: begin
                state_d       = S_IDLE;
                instr_valid_d = 1'b0;
                done_d        = 1'b0;
            end
        endcase
    end

    // imem_addr is the live PC so memory read data lines up with this cycle.
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.done        = done_q;
    assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. A behavioural model of the fetch stage
// (PC_W=10 instance) is compared against the DUT on every falling edge;
// directed checks with literal expectations pin the model. A second
// instance with PC_W=4, CNT_W=3 exercises PC wrap and count saturation.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    logic clk;
    logic reset;

    fetch_unit_if #(.PC_W(10), .CNT_W(16)) bus10 ();
    fetch_unit_if #(.PC_W(4),  .CNT_W(3))  bus4  ();

    fetch_unit #(.PC_W(10), .HALT_INSTR(9'h1FF), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus10)
    );

    fetch_unit #(.PC_W(4), .HALT_INSTR(9'h1FF), .CNT_W(3)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    logic [8:0] mem  [0:1023];
    logic [8:0] mem4 [0:15];

    assign bus10.imem_data = mem[bus10.imem_addr];
    assign bus4.imem_data  = mem4[bus4.imem_addr];

    int n_chk  = 0;
    int n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (PC_W=10, CNT_W=16) ----------------
    // mode: 0 = not started, 1 = executing, 2 = halted
    int         m_mode;
    int         m_pc;
    int         m_ipc;
    int         m_cnt;
    logic [8:0] m_instr;
    logic       m_valid;

    // Model advances on each rising edge using the spec's fetch rules.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode  <= 0;
            m_pc    <= 0;
            m_ipc   <= 0;
            m_cnt   <= 0;
            m_instr <= 9'h000;
            m_valid <= 1'b0;
        end else if (m_mode == 1) begin
            if (bus10.branch_taken) begin
                m_pc    <= int'(bus10.branch_target);
                m_valid <= 1'b0;
            end else if (!bus10.stall) begin
                if (mem[m_pc] == 9'h1FF) begin
                    m_mode  <= 2;
                    m_valid <= 1'b0;
                end else begin
                    m_instr <= mem[m_pc];
                    m_ipc   <= m_pc;
                    m_valid <= 1'b1;
                    m_pc    <= (m_pc + 1) % 1024;
                    m_cnt   <= (m_cnt == 65535) ? m_cnt : m_cnt + 1;
                end
            end
        end else begin
            if (bus10.start) begin
                m_mode <= 1;
                m_pc   <= 0;
                m_cnt  <= 0;
            end
        end
    end

    // Cycle-by-cycle comparison of the main DUT against the model.
    always @(negedge clk) begin
        chk("cmp_addr",  32'(bus10.imem_addr),   32'(m_pc));
        chk("cmp_instr", 32'(bus10.instr),       32'(m_instr));
        chk("cmp_ipc",   32'(bus10.instr_pc),    32'(m_ipc));
        chk("cmp_valid", 32'(bus10.instr_valid), 32'(m_valid));
        chk("cmp_done",  32'(bus10.done),        32'(m_mode == 2));
        chk("cmp_cnt",   32'(bus10.fetch_count), 32'(m_cnt));
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    logic [8:0] q_instr[$];
    int         q_ipc[$];
    bit         found;

    // Directed stimulus with hand-computed expectations.
    initial begin
        reset = 1'b1;
        bus10.start = 1'b0; bus10.stall = 1'b0;
        bus10.branch_taken = 1'b0; bus10.branch_target = 10'h000;
        bus4.start = 1'b0; bus4.stall = 1'b0;
        bus4.branch_taken = 1'b0; bus4.branch_target = 4'h0;
        for (int i = 0; i < 1024; i++) mem[i] = 9'((i * 7 + 3) & 255);
        mem[0] = 9'h010; mem[1] = 9'h021; mem[2] = 9'h032; mem[3] = 9'h043;
        mem[4] = 9'h1FF;
        for (int i = 0; i < 16; i++) mem4[i] = 9'(9'h030 + i);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(bus10.instr_valid), 32'h0);
        chk("rst_done",  32'(bus10.done),        32'h0);
        chk("rst_cnt",   32'(bus10.fetch_count), 32'h0);
        chk("rst_addr",  32'(bus10.imem_addr),   32'h0);
        chk("rst_instr", 32'(bus10.instr),       32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_valid", 32'(bus10.instr_valid), 32'h0);

        // Straight-line program ending in halt
        bus10.start = 1'b1;
        @(negedge clk);
        bus10.start = 1'b0;
        chk("run_first_valid", 32'(bus10.instr_valid), 32'h0);
        chk("run_first_addr",  32'(bus10.imem_addr),   32'h0);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (bus10.instr_valid) begin
                q_instr.push_back(bus10.instr);
                q_ipc.push_back(int'(bus10.instr_pc));
            end
            if (bus10.done) found = 1'b1;
        end
        chk("halt_reached", 32'(found), 32'h1);
        chk("halt_nwords", 32'(q_instr.size()), 32'h4);
        for (int i = 0; i < 4 && i < q_instr.size(); i++) begin
            chk("seq_instr", 32'(q_instr[i]), 32'(9'h010 + 9'(i) * 9'h011));
            chk("seq_ipc",   32'(q_ipc[i]),   32'(i));
        end
        chk("halt_cnt",   32'(bus10.fetch_count), 32'h4);
        chk("halt_addr",  32'(bus10.imem_addr),   32'h4);
        chk("halt_valid", 32'(bus10.instr_valid), 32'h0);

        // Restart from HALTED; stall while instr=021
        mem[4] = 9'h054;
        bus10.start = 1'b1;
        @(negedge clk);
        bus10.start = 1'b0;
        chk("restart_done", 32'(bus10.done), 32'h0);
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (bus10.instr_valid && bus10.instr == 9'h021) found = 1'b1;
        end
        chk("stall_setup", 32'(found), 32'h1);
        bus10.stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_instr", 32'(bus10.instr),     32'h021);
            chk("stall_ipc",   32'(bus10.instr_pc),  32'h1);
            chk("stall_addr",  32'(bus10.imem_addr), 32'h2);
        end
        bus10.stall = 1'b0;
        @(negedge clk);
        chk("unstall_instr", 32'(bus10.instr),    32'h032);
        chk("unstall_ipc",   32'(bus10.instr_pc), 32'h2);

        // Branch at imem_addr=5 to 0x020
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            if (bus10.imem_addr == 10'd5) found = 1'b1;
            else @(negedge clk);
        end
        chk("br_setup", 32'(found), 32'h1);
        bus10.branch_taken = 1'b1; bus10.branch_target = 10'h020;
        @(negedge clk);
        bus10.branch_taken = 1'b0;
        chk("br_valid", 32'(bus10.instr_valid), 32'h0);
        chk("br_addr",  32'(bus10.imem_addr),   32'h020);
        chk("br_cnt",   32'(bus10.fetch_count), 32'h5);
        @(negedge clk);
        chk("br_instr", 32'(bus10.instr),       32'h0E3);
        chk("br_ipc",   32'(bus10.instr_pc),    32'h020);
        chk("br_cnt2",  32'(bus10.fetch_count), 32'h6);

        // Branch together with stall
        bus10.branch_taken = 1'b1; bus10.stall = 1'b1; bus10.branch_target = 10'h040;
        @(negedge clk);
        bus10.branch_taken = 1'b0; bus10.stall = 1'b0;
        chk("brst_addr",  32'(bus10.imem_addr),   32'h040);
        chk("brst_valid", 32'(bus10.instr_valid), 32'h0);
        chk("brst_done",  32'(bus10.done),        32'h0);

        // Branch while the halt word is on imem_data
        mem[10'h050] = 9'h1FF;
        bus10.branch_taken = 1'b1; bus10.branch_target = 10'h050;
        @(negedge clk);
        chk("brh_data", 32'(bus10.imem_data), 32'h1FF);
        bus10.branch_target = 10'h060;
        @(negedge clk);
        bus10.branch_taken = 1'b0;
        chk("brh_addr", 32'(bus10.imem_addr), 32'h060);
        chk("brh_done", 32'(bus10.done),      32'h0);
        @(negedge clk);
        chk("brh_valid", 32'(bus10.instr_valid), 32'h1);
        chk("brh_ipc",   32'(bus10.instr_pc),    32'h060);

        // Asynchronous reset mid-RUN at pc=7
        bus10.branch_taken = 1'b1; bus10.branch_target = 10'h004;
        @(negedge clk);
        bus10.branch_taken = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            if (bus10.imem_addr == 10'd7) found = 1'b1;
            else @(negedge clk);
        end
        chk("arst_setup", 32'(found), 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("arst_addr",  32'(bus10.imem_addr),   32'h0);
        chk("arst_instr", 32'(bus10.instr),       32'h0);
        chk("arst_ipc",   32'(bus10.instr_pc),    32'h0);
        chk("arst_valid", 32'(bus10.instr_valid), 32'h0);
        chk("arst_done",  32'(bus10.done),        32'h0);
        chk("arst_cnt",   32'(bus10.fetch_count), 32'h0);
        bus10.start = 1'b1;
        @(negedge clk);
        bus10.start = 1'b0;
        chk("arst_start_ign", 32'(bus10.instr_valid), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_idle_valid", 32'(bus10.instr_valid), 32'h0);
        chk("post_rst_idle_addr",  32'(bus10.imem_addr),   32'h0);

        // Halt at word 3, HALTED ignores branch/stall, then restart
        mem[3] = 9'h1FF;
        bus10.start = 1'b1;
        @(negedge clk);
        bus10.start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (bus10.done) found = 1'b1;
        end
        chk("h2_reached", 32'(found), 32'h1);
        chk("h2_cnt",  32'(bus10.fetch_count), 32'h3);
        chk("h2_addr", 32'(bus10.imem_addr),   32'h3);
        bus10.branch_taken = 1'b1; bus10.stall = 1'b1; bus10.branch_target = 10'h100;
        @(negedge clk);
        bus10.branch_taken = 1'b0; bus10.stall = 1'b0;
        chk("h2_ign_done", 32'(bus10.done),      32'h1);
        chk("h2_ign_addr", 32'(bus10.imem_addr), 32'h3);
        bus10.start = 1'b1;
        @(negedge clk);
        bus10.start = 1'b0;
        chk("h2_rs_done",  32'(bus10.done),        32'h0);
        chk("h2_rs_cnt",   32'(bus10.fetch_count), 32'h0);
        chk("h2_rs_addr",  32'(bus10.imem_addr),   32'h0);
        chk("h2_rs_valid", 32'(bus10.instr_valid), 32'h0);
        @(negedge clk);
        chk("h2_rs_instr", 32'(bus10.instr),       32'h010);
        chk("h2_rs_ipc",   32'(bus10.instr_pc),    32'h0);

        // PC wrap and count saturation on the PC_W=4 / CNT_W=3 instance
        bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        chk("w_first_valid", 32'(bus4.instr_valid), 32'h0);
        chk("w_first_addr",  32'(bus4.imem_addr),   32'h0);
        for (int k = 2; k <= 22; k++) begin
            @(negedge clk);
            chk("w_valid", 32'(bus4.instr_valid), 32'h1);
            chk("w_ipc",   32'(bus4.instr_pc),    32'((k - 2) % 16));
            chk("w_instr", 32'(bus4.instr),       32'(9'h030 + 9'((k - 2) % 16)));
            chk("w_addr",  32'(bus4.imem_addr),   32'((k - 1) % 16));
            chk("w_cnt",   32'(bus4.fetch_count), 32'(((k - 1) > 7) ? 7 : (k - 1)));
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage of the R.O.E 9-bit core; sits directly upstream of the control decoder.
- Holds the program counter and drives the instruction memory address.
- Registers the fetched 9-bit word into the IF/ID pipeline register that feeds control and the register file.
- Handles start/halt sequencing, branch redirect/flush, stall hold, and a retired-fetch counter.

Parameters:
- PC_W, 10, program counter and instruction memory address width.
- HALT_INSTR, 9'h1FF, encoding that halts fetch when fetched.
- CNT_W, 16, width of the fetch counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  begin or restart execution from PC 0; honoured only in IDLE or HALTED.
- stall  in  1  hold PC and the IF/ID register.
- branch_taken  in  1  redirect request from the downstream stage.
- branch_target  in  PC_W  absolute redirect address.
- imem_data  in  9  instruction memory read data; combinational read of imem_addr.
- imem_addr  out  PC_W  equals pc.
- instr  out  9  IF/ID instruction register, consumed by the control decoder.
- instr_pc  out  PC_W  address of the word held in instr.
- instr_valid  out  1  instr holds a live instruction.
- done  out  1  high while in HALTED.
- fetch_count  out  CNT_W  number of words captured with instr_valid=1; saturating.

Behaviour:
- Reset values: pc=0, instr=9'h000, instr_pc=0, instr_valid=0, done=0, fetch_count=0, state=IDLE.
- State machine, three states: IDLE, RUN, HALTED.
- IDLE:
  - pc and the IF/ID register hold; instr_valid=0.
  - start=1 -> next state RUN, pc<=0, fetch_count<=0.
- RUN, evaluated each edge in this priority order:
  1. branch_taken=1 (beats stall and halt):
     - pc<=branch_target, instr_valid<=0, instr holds.
     - The word on imem_data that cycle is discarded, never counted, never halt-checked.
  2. stall=1:
     - pc, instr, instr_pc, instr_valid and fetch_count all hold.
     - imem_addr stays stable.
  3. imem_data==HALT_INSTR:
     - next state HALTED, instr_valid<=0, done<=1, pc holds.
     - The halt word is not passed downstream and not counted.
  4. Otherwise:
     - instr<=imem_data, instr_pc<=pc, instr_valid<=1.
     - pc<=pc+1, modulo 2^PC_W: 2^PC_W-1 wraps to 0 with no flag.
     - fetch_count<=fetch_count+1, saturating at 2^CNT_W-1.
  - start in RUN is ignored.
- Latency:
  - A word addressed in cycle N appears on instr in cycle N+1.
  - The first valid instr arrives 2 cycles after start is sampled: one cycle to enter RUN with pc=0, one to capture.
- HALTED:
  - done=1, instr_valid=0; pc and fetch_count hold.
  - stall and branch_taken are ignored.
  - start=1 -> RUN, pc<=0, fetch_count<=0, done<=0.
- Reset asserted mid-operation (any state, any cycle) forces reset values asynchronously. The first activity after reset release requires start.
- Branch and stall asserted together in RUN: the branch wins; the stalled word is flushed.
- Outputs are registered except imem_addr, which is a direct copy of pc.

Test Plan:
- Reset, then start=1 for one cycle with imem preloaded 0..4 = 9'h010,9'h021,9'h032,9'h043,9'h1FF -> instr shows 010,021,032,043 on consecutive cycles with instr_pc 0..3; then done=1, instr_valid=0, fetch_count=4, pc=4.
- Run straight-line code; hold stall=1 for 3 cycles while instr=9'h021 -> instr, instr_pc=1 and imem_addr=2 constant for 3 cycles; resumes with 9'h032 on the cycle after stall drops.
- branch_taken=1 with branch_target=10'h020 while imem_addr=5 -> next cycle instr_valid=0, pc=0x020; the following cycle instr=mem[0x020], instr_pc=0x020; fetch_count excludes word 5.
- branch_taken=1 and stall=1 together, and separately branch_taken=1 while imem_data=HALT_INSTR -> pc=target in both cases, state stays RUN, done=0.
- PC wrap with PC_W=4 and non-halt words at all addresses -> pc goes 15 to 0, instr_pc sequence ...,14,15,0,1.
- Pulse reset mid-RUN at pc=7 -> all outputs return to reset values within the same cycle, with no clock edge needed; start is then ignored until reset drops. In HALTED, start=1 restarts at pc=0 with fetch_count=0 and done=0.
